x_uart_tx_arb: RTL
==================

Name: x_uart_tx_arb

Overview:
- Round-robin arbiter that shares one UART byte transmitter among p_num requesters.
- Sits between in-fabric byte producers and the UART TX front end, in the same clock domain, downstream of the PLL/clock mux.
- Holds a grant for a whole packet (up to `i_req_last`), with a burst cap and an optional inter-byte guard gap.

Parameters:
- p_num, 4, number of requesters (legal 2..8)
- p_gap, 0, idle cycles forced after every accepted byte (0..255)
- p_max_burst, 16, max bytes per grant before forced rotation; 0 = unlimited

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-low (asserted at 0)
- i_req_valid  in  p_num  requester k has a byte
- i_req_data  in  8*p_num  byte of requester k at [8k+7:8k]
- i_req_last  in  p_num  byte of requester k ends its packet
- o_req_ready  out  p_num  byte of requester k accepted this cycle
- o_grant  out  p_num  one-hot current grant, 0 when idle
- o_tx_valid  out  1  byte offered to transmitter
- o_tx_data  out  8  byte to transmitter
- i_tx_ready  in  1  transmitter accepts byte (handshake = valid & ready)
- o_busy  out  1  arbiter not in IDLE

Behaviour:
- Reset (i_rst=0, async):
  - state=IDLE; all outputs 0.
  - rr pointer = p_num-1, so requester 0 wins first.
  - burst and gap counters = 0.
- States: IDLE, GRANT, GAP (plus TAG with optional feature).
- IDLE:
  - If any `i_req_valid`, pick the first set bit searching from (ptr+1) mod p_num upward with wrap.
  - Register `o_grant` (one-hot, index g); next state GRANT.
  - Requester valid at cycle n gives `o_tx_valid` at cycle n+1 at the earliest.
  - `o_req_ready`=0 in IDLE.
- GRANT:
  - `o_tx_valid` = `i_req_valid[g]`; `o_tx_data` = `i_req_data[g]`, combinational pass-through.
  - `o_req_ready[g]` = `i_tx_ready`; all other ready bits 0.
  - No handshake: stay in GRANT.
  - Handshake: burst_cnt++. release = `i_req_last[g]`, or (p_max_burst != 0 and burst_cnt+1 == p_max_burst).
  - On release: ptr=g. Next state GAP if p_gap>0, else IDLE with `o_grant`=0 next cycle.
  - No release: next state GAP if p_gap>0, else remain in GRANT (back-to-back bytes allowed).
- GAP:
  - `o_tx_valid`=0; all ready=0; counts p_gap cycles.
  - Then go to IDLE if release is pending (release flag registered), else back to GRANT with the same grant.
  - `o_grant` holds through GAP and clears on entry to IDLE.
- burst_cnt clears on every release; width is clog2(p_max_burst+1), min 1.
- Grantee dropping valid mid-packet without last: grant is held indefinitely. There is no timeout, and other requesters wait.
- Releasing requester re-requesting immediately: it gets lowest priority. If it is the only requester, it is re-granted after one IDLE cycle.
- Simultaneous requests: resolved strictly by rr order; only one grant at a time.
- `o_busy` = (state != IDLE).
- Reset mid-packet: the byte in flight is abandoned and there is no partial handshake. The state machine returns to IDLE.

Optional Feature:
- Macro X_UART_TX_ARB_TAG_EN.
- Defined:
  - IDLE goes to TAG instead of GRANT.
  - TAG drives `o_tx_valid`=1 and `o_tx_data`=8'hA0 | g[3:0]; all `o_req_ready`=0.
  - On handshake TAG goes to GRANT with no gap.
  - The tag byte does not count toward burst_cnt.
- Undefined: TAG state absent, so there is no header byte and IDLE goes directly to GRANT.

Test Plan:
- Reset then req0 sends 3 bytes 0x11,0x22,0x33 with last on 0x33, `i_tx_ready`=1, p_gap=0 -> tx sees 0x11,0x22,0x33 on consecutive cycles; `o_grant`=4'b0001 then 0; `o_busy` falls 1 cycle after the last handshake.
- All 4 requesters valid with single-byte packets (last=1) -> grant order 0,1,2,3,0; each byte appears once; `o_req_ready` only on the granted index.
- req2 streams 40 bytes with no last, p_max_burst=16, req1 also valid -> after 16 bytes the grant moves to req1; req2 resumes after req1's packet ends.
- p_gap=3, req1 sends 0xAA,0xBB -> exactly 3 cycles with `o_tx_valid`=0 between the handshakes and after 0xBB; grant stays 4'b0010 through the first gap.
- `i_tx_ready` held low 10 cycles mid-packet, then i_rst=0 for 1 cycle -> `o_tx_data`/`o_tx_valid` stable while stalled; after reset all outputs 0, and req0 wins the next arbitration.
- With X_UART_TX_ARB_TAG_EN, req3 sends 0x55 last -> tx sees 0xA3 then 0x55; `o_req_ready[3]` low during the 0xA3 handshake.

Source files
------------

// File: rtl/x_uart_tx_arb.sv
// Round-robin arbiter sharing one UART byte transmitter among p_num packet producers.
// Optional grant header byte (8'hA0 | index) before each grant: define X_UART_TX_ARB_TAG_EN.
module x_uart_tx_arb #(
    parameter int p_num       = 4,
    parameter int p_gap       = 0,
    parameter int p_max_burst = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_num-1:0]   i_req_valid,
    input  logic [8*p_num-1:0] i_req_data,
    input  logic [p_num-1:0]   i_req_last,
    output logic [p_num-1:0]   o_req_ready,
    output logic [p_num-1:0]   o_grant,
    output logic               o_tx_valid,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_ready,
    output logic               o_busy
);

    localparam int IW = (p_num > 1) ? $clog2(p_num) : 1;
    localparam int BW = (p_max_burst > 0) ? $clog2(p_max_burst + 1) : 1;
    localparam logic [7:0]   GAP_LAST  = (p_gap > 0) ? 8'(p_gap - 1) : 8'd0;
    localparam logic [BW:0]  BURST_MAX = (BW+1)'(p_max_burst);
    localparam logic [BW:0]  BURST_ONE = (BW+1)'(1);
    localparam logic [p_num-1:0] ONE_HOT0 = p_num'(1);

`ifdef X_UART_TX_ARB_TAG_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_GAP = 2'd2, S_TAG = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_GAP = 2'd2} state_t;
`endif

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [p_num-1:0]  grant_q, grant_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [7:0]        gap_q, gap_d;
    logic              rel_q, rel_d;

    logic [IW:0]       pick;
    logic [BW:0]       burst_inc;
    logic [7:0]        sel_data;
    logic              hs;
    logic              rel_now;

    // Nearest set bit after ptr wins; scanning far-to-near lets the nearest overwrite.
    function automatic logic [IW:0] rr_pick(input logic [p_num-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int i = p_num; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= p_num) idx = idx - p_num;
            if (req[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    assign pick      = rr_pick(i_req_valid, ptr_q);
    assign burst_inc = {1'b0, burst_q} + BURST_ONE;
    assign sel_data  = i_req_data[8*int'(gidx_q) +: 8];
    assign o_grant   = grant_q;
    assign o_busy    = (state_q != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(p_num - 1);
            gidx_q  <= '0;
            grant_q <= '0;
            burst_q <= '0;
            gap_q   <= '0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        burst_d     = burst_q;
        gap_d       = gap_q;
        rel_d       = rel_q;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        o_req_ready = '0;
        hs          = 1'b0;
        rel_now     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick[IW]) begin
                    gidx_d  = pick[IW-1:0];
                    grant_d = ONE_HOT0 << pick[IW-1:0];
                    burst_d = '0;
                    rel_d   = 1'b0;
`ifdef X_UART_TX_ARB_TAG_EN
                    state_d = S_TAG;
`else
                    state_d = S_GRANT;
`endif
                end
            end

            S_GRANT: begin
                o_tx_valid  = i_req_valid[gidx_q];
                o_tx_data   = sel_data;
                o_req_ready = grant_q & {p_num{i_tx_ready}};
                hs          = i_req_valid[gidx_q] & i_tx_ready;
                if (hs) begin
                    rel_now = i_req_last[gidx_q] || ((p_max_burst != 0) && (burst_inc == BURST_MAX));
                    gap_d   = 8'd0;
                    rel_d   = rel_now;
                    if (rel_now) begin
                        ptr_d   = gidx_q;
                        burst_d = '0;
                        if (p_gap > 0) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                            grant_d = '0;
                        end
                    end else begin
                        burst_d = burst_inc[BW-1:0];
                        if (p_gap > 0) state_d = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (rel_q) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = S_GRANT;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

`ifdef X_UART_TX_ARB_TAG_EN
            // Header byte is not a requester byte: no ready, no burst count, no gap after it.
            S_TAG: begin
                o_tx_valid = 1'b1;
                o_tx_data  = 8'hA0 | {4'h0, 4'(gidx_q)};
                if (i_tx_ready) state_d = S_GRANT;
            end
`endif

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule
